// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
//   Shared types and constants for pll_lock_sequencer:
//   - seq_state_e   : main sequencer states (3-bit encoding)
//   - phase_state_e : phase-step sub-states (used with PLL_PHASE_STEP_EN)
//   - PHASE_SETUP / PHASE_PULSE / PHASE_HOLD : phase-step segment lengths
//   - cnt_width()   : width of the shared sequencer counter
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    FILTER    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } seq_state_e;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_SETUP = 3'd1,
    PH_PULSE = 3'd2,
    PH_HOLD  = 3'd3,
    PH_ACK   = 3'd4
  } phase_state_e;

  localparam int PHASE_SETUP = 4;
  localparam int PHASE_PULSE = 4;
  localparam int PHASE_HOLD  = 4;
  localparam int PHASE_CNT_W = 3;

  // Counter width: enough bits for the largest interval the sequencer times,
  // plus one spare bit so the terminal value never sits on the top bit.
  function automatic int cnt_width(input int a, input int b, input int c,
                                   input int d, input int e);
    int m;
    m = a;
    m = (b > m) ? b : m;
    m = (c > m) ? c : m;
    m = (d > m) ? d : m;
    m = (e > m) ? e : m;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for asynchronous level inputs.
//   Ports:
//     clk_i : destination clock
//     rst_i : asynchronous active-high reset, clears both stages to 0
//     d_i   : asynchronous input [WIDTH]
//     q_o   : synchronised output [WIDTH], two clk_i edges of latency
module sync_2ff
  import pll_seq_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Synchroniser chain: first stage may go metastable, second stage resolves.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   PLL supervisor on the reference clock. Pulses the PLL RST, waits for a
//   filtered LOCK, then releases the downstream domain resets in order
//   (bit 0 first). A lock loss or forced relock re-asserts every domain
//   reset and restarts the sequence.
//   Optional build macro: PLL_PHASE_STEP_EN adds a phase-step engine that
//   drives the EHXPLLL dynamic phase ports while in RUN.
//   Ports:
//     clkin         : reference clock
//     rst           : asynchronous active-high reset
//     pll_locked    : PLL LOCK (asynchronous, synchronised internally)
//     force_relock  : 1-cycle request to restart the sequence
//     pll_rst       : PLL RST
//     domain_rst    : per-domain active-high resets [NUM_DOMAINS]
//     ready         : high only in RUN
//     relock_count  : saturating count of lock losses / forced relocks
//     timeout_count : saturating count of lock-wait timeouts
//   With PLL_PHASE_STEP_EN:
//     phase_req/phase_sel/phase_dir in, phase_ack out,
//     pll_phasesel/pll_phasedir/pll_phasestep/pll_phaseloadreg out
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS  = 3,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int RELEASE_GAP  = 256,
  parameter int LOCK_TIMEOUT = 1048576
) (
  input  logic                   clkin,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   force_relock,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [7:0]             relock_count,
  output logic [7:0]             timeout_count
`ifdef PLL_PHASE_STEP_EN
  ,
  input  logic                   phase_req,
  input  logic [1:0]             phase_sel,
  input  logic                   phase_dir,
  output logic                   phase_ack,
  output logic [1:0]             pll_phasesel,
  output logic                   pll_phasedir,
  output logic                   pll_phasestep,
  output logic                   pll_phaseloadreg
`endif
);

  localparam int RELEASE_SPAN = (NUM_DOMAINS - 1) * RELEASE_GAP;
  localparam int CW = cnt_width(RST_PULSE, LOCK_FILTER, RELEASE_GAP,
                                LOCK_TIMEOUT, RELEASE_SPAN);

  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] FILTER_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_SPAN);

  logic                   lock_s;
  logic                   loss_s;
  logic                   relock_inc_s;
  logic                   timeout_inc_s;

  seq_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             relock_count_q, relock_count_d;
  logic [7:0]             timeout_count_q, timeout_count_d;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i (clkin),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lock_s)
  );

  // A loss event only matters once domains have started coming out of reset.
  assign loss_s = ((state_q == RELEASE) || (state_q == RUN)) &&
                  (!lock_s || force_relock);

  // Next-state and shared interval counter; the counter restarts on every
  // state entry so one counter serves all states without wrapping.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_ONE;
    relock_inc_s  = 1'b0;
    timeout_inc_s = 1'b0;
    case (state_q)
      PLL_RST: begin
        // force_relock is deliberately ignored while the PLL is held in reset
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      WAIT_LOCK: begin
        if (force_relock) begin
          state_d = PLL_RST;
          cnt_d   = CNT_ZERO;
        end else if (lock_s) begin
          state_d = FILTER;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = PLL_RST;
          cnt_d         = CNT_ZERO;
          timeout_inc_s = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      FILTER: begin
        if (force_relock) begin
          state_d = PLL_RST;
          cnt_d   = CNT_ZERO;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == FILTER_LAST) begin
          state_d = RELEASE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      RELEASE: begin
        if (loss_s) begin
          state_d      = PLL_RST;
          cnt_d        = CNT_ZERO;
          relock_inc_s = 1'b1;
        end else if (cnt_q == RELEASE_LAST) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        if (loss_s) begin
          state_d      = PLL_RST;
          cnt_d        = CNT_ZERO;
          relock_inc_s = 1'b1;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so each output
  // changes on the same edge as the state it belongs to.
  always_comb begin
    pll_rst_d       = (state_d == PLL_RST);
    ready_d         = (state_d == RUN);
    domain_rst_d    = {NUM_DOMAINS{1'b1}};
    domain_rst_d[0] = !((state_d == RELEASE) || (state_d == RUN));
    // Bit i drops once the release counter reaches i*RELEASE_GAP.
    for (int i = 1; i < NUM_DOMAINS; i++) begin
      domain_rst_d[i] = !((state_d == RUN) ||
                          ((state_d == RELEASE) && (cnt_d >= CW'(i * RELEASE_GAP))));
    end
    if (relock_inc_s && (relock_count_q != 8'hFF)) begin
      relock_count_d = relock_count_q + 8'd1;
    end else begin
      relock_count_d = relock_count_q;
    end
    if (timeout_inc_s && (timeout_count_q != 8'hFF)) begin
      timeout_count_d = timeout_count_q + 8'd1;
    end else begin
      timeout_count_d = timeout_count_q;
    end
  end

  // Sequencer state, counter and output registers.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q         <= PLL_RST;
      cnt_q           <= CNT_ZERO;
      pll_rst_q       <= 1'b1;
      domain_rst_q    <= {NUM_DOMAINS{1'b1}};
      ready_q         <= 1'b0;
      relock_count_q  <= 8'd0;
      timeout_count_q <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pll_rst_q       <= pll_rst_d;
      domain_rst_q    <= domain_rst_d;
      ready_q         <= ready_d;
      relock_count_q  <= relock_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign domain_rst    = domain_rst_q;
  assign ready         = ready_q;
  assign relock_count  = relock_count_q;
  assign timeout_count = timeout_count_q;

`ifdef PLL_PHASE_STEP_EN
  localparam logic [PHASE_CNT_W-1:0] PH_ZERO     = {PHASE_CNT_W{1'b0}};
  localparam logic [PHASE_CNT_W-1:0] PH_ONE      = PHASE_CNT_W'(1);
  localparam logic [PHASE_CNT_W-1:0] SETUP_LAST  = PHASE_CNT_W'(PHASE_SETUP - 1);
  localparam logic [PHASE_CNT_W-1:0] PULSE_LAST  = PHASE_CNT_W'(PHASE_PULSE - 1);
  localparam logic [PHASE_CNT_W-1:0] HOLD_LAST   = PHASE_CNT_W'(PHASE_HOLD - 1);

  phase_state_e           ph_state_q, ph_state_d;
  logic [PHASE_CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [1:0]             ph_sel_q, ph_sel_d;
  logic                   ph_dir_q, ph_dir_d;
  logic                   ph_step_q, ph_step_d;
  logic                   ph_ack_q, ph_ack_d;

  // Phase-step engine: only runs in RUN; a loss event drops it straight back
  // to idle without an ack so the held request is replayed after relock.
  always_comb begin
    ph_state_d = ph_state_q;
    ph_cnt_d   = ph_cnt_q + PH_ONE;
    ph_sel_d   = ph_sel_q;
    ph_dir_d   = ph_dir_q;
    ph_step_d  = 1'b0;
    ph_ack_d   = 1'b0;
    if ((state_q != RUN) || loss_s) begin
      ph_state_d = PH_IDLE;
      ph_cnt_d   = PH_ZERO;
      ph_sel_d   = 2'b00;
      ph_dir_d   = 1'b0;
    end else begin
      case (ph_state_q)
        PH_IDLE: begin
          ph_cnt_d = PH_ZERO;
          if (phase_req) begin
            ph_state_d = PH_SETUP;
            ph_sel_d   = phase_sel;
            ph_dir_d   = phase_dir;
          end else begin
            ph_sel_d   = 2'b00;
            ph_dir_d   = 1'b0;
          end
        end
        PH_SETUP: begin
          if (ph_cnt_q == SETUP_LAST) begin
            ph_state_d = PH_PULSE;
            ph_cnt_d   = PH_ZERO;
            ph_step_d  = 1'b1;
          end else begin
            ph_cnt_d   = ph_cnt_q + PH_ONE;
          end
        end
        PH_PULSE: begin
          if (ph_cnt_q == PULSE_LAST) begin
            ph_state_d = PH_HOLD;
            ph_cnt_d   = PH_ZERO;
          end else begin
            ph_step_d  = 1'b1;
          end
        end
        PH_HOLD: begin
          if (ph_cnt_q == HOLD_LAST) begin
            ph_state_d = PH_ACK;
            ph_cnt_d   = PH_ZERO;
            ph_ack_d   = 1'b1;
          end else begin
            ph_cnt_d   = ph_cnt_q + PH_ONE;
          end
        end
        PH_ACK: begin
          ph_state_d = PH_IDLE;
          ph_cnt_d   = PH_ZERO;
          ph_sel_d   = 2'b00;
          ph_dir_d   = 1'b0;
        end
        default: begin
          ph_state_d = PH_IDLE;
          ph_cnt_d   = PH_ZERO;
          ph_sel_d   = 2'b00;
          ph_dir_d   = 1'b0;
        end
      endcase
    end
  end

  // Phase-step state and output registers.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      ph_state_q <= PH_IDLE;
      ph_cnt_q   <= PH_ZERO;
      ph_sel_q   <= 2'b00;
      ph_dir_q   <= 1'b0;
      ph_step_q  <= 1'b0;
      ph_ack_q   <= 1'b0;
    end else begin
      ph_state_q <= ph_state_d;
      ph_cnt_q   <= ph_cnt_d;
      ph_sel_q   <= ph_sel_d;
      ph_dir_q   <= ph_dir_d;
      ph_step_q  <= ph_step_d;
      ph_ack_q   <= ph_ack_d;
    end
  end

  assign phase_ack        = ph_ack_q;
  assign pll_phasesel     = ph_sel_q;
  assign pll_phasedir     = ph_dir_q;
  assign pll_phasestep    = ph_step_q;
  assign pll_phaseloadreg = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
//   Directed bench for pll_lock_sequencer with NUM_DOMAINS=3, RST_PULSE=4,
//   LOCK_FILTER=8, RELEASE_GAP=5, LOCK_TIMEOUT=64. Cycle n is the value seen
//   at the n-th falling edge after rst is released (cycle 0 = release edge).
//   A pll_locked change made at cycle n reaches the FSM's decision at the
//   rising edge n+3 and shows on the outputs at cycle n+3.
module tb_pll_lock_sequencer;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;
`ifdef PLL_PHASE_STEP_EN
  logic       phase_req = 1'b0;
  logic [1:0] phase_sel = 2'b00;
  logic       phase_dir = 1'b0;
  logic       phase_ack;
  logic [1:0] pll_phasesel;
  logic       pll_phasedir;
  logic       pll_phasestep;
  logic       pll_phaseloadreg;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  pll_lock_sequencer #(
    .NUM_DOMAINS(3), .RST_PULSE(4), .LOCK_FILTER(8),
    .RELEASE_GAP(5), .LOCK_TIMEOUT(64)
  ) dut (
    .clkin(clkin), .rst(rst), .pll_locked(pll_locked), .force_relock(force_relock),
    .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready),
    .relock_count(relock_count), .timeout_count(timeout_count)
`ifdef PLL_PHASE_STEP_EN
    , .phase_req(phase_req), .phase_sel(phase_sel), .phase_dir(phase_dir),
    .phase_ack(phase_ack), .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir),
    .pll_phasestep(pll_phasestep), .pll_phaseloadreg(pll_phaseloadreg)
`endif
  );

  always #5 clkin = ~clkin;

  task automatic step();
    @(negedge clkin);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
`ifdef PLL_PHASE_STEP_EN
    phase_req = 1'b0;
    phase_sel = 2'b00;
    phase_dir = 1'b0;
`endif
    repeat (2) @(negedge clkin);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    force_relock = 1'b0;
    repeat (2) @(negedge clkin);
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL rst_domain got=%b exp=111", domain_rst); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready); end
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL rst_relock got=%0d exp=0", relock_count); end
    checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL rst_timeout got=%0d exp=0", timeout_count); end
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i <= 25; i++) begin
      if (i > 0) step();
      if (cyc == 10) pll_locked = 1'b1;
    end
    checks++; if (domain_rst !== 3'b110) begin errors++; $display("FAIL rst_pre_domain got=%b exp=110", domain_rst); end
    // Asynchronous reset between clock edges must act immediately.
    #2 rst = 1'b1;
    #1;
    checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL rst_async_domain got=%b exp=111", domain_rst); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rst_async_pll_rst got=%b exp=1", pll_rst); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_async_ready got=%b exp=0", ready); end
  endtask

  task automatic test_nominal();
    logic [2:0] exp_dr;
    do_reset();
    for (int i = 0; i <= 35; i++) begin
      if (i > 0) step();
      exp_dr = {(cyc < 31), (cyc < 26), (cyc < 21)};
      checks++; if (pll_rst !== (cyc <= 3)) begin errors++; $display("FAIL nom_pll_rst c=%0d got=%b exp=%b", cyc, pll_rst, (cyc <= 3)); end
      checks++; if (domain_rst !== exp_dr) begin errors++; $display("FAIL nom_domain c=%0d got=%b exp=%b", cyc, domain_rst, exp_dr); end
      checks++; if (ready !== (cyc >= 32)) begin errors++; $display("FAIL nom_ready c=%0d got=%b exp=%b", cyc, ready, (cyc >= 32)); end
      if (cyc == 10) pll_locked = 1'b1;
    end
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL nom_relock got=%0d exp=0", relock_count); end
    checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL nom_timeout got=%0d exp=0", timeout_count); end
  endtask

  task automatic test_glitch();
    logic [2:0] exp_dr;
    do_reset();
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) step();
      exp_dr = {(cyc < 37), (cyc < 32), (cyc < 27)};
      checks++; if (domain_rst !== exp_dr) begin errors++; $display("FAIL glitch_domain c=%0d got=%b exp=%b", cyc, domain_rst, exp_dr); end
      checks++; if (ready !== (cyc >= 38)) begin errors++; $display("FAIL glitch_ready c=%0d got=%b exp=%b", cyc, ready, (cyc >= 38)); end
      if (cyc == 10) pll_locked = 1'b1;
      if (cyc == 15) pll_locked = 1'b0;
      if (cyc == 16) pll_locked = 1'b1;
    end
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL glitch_relock got=%0d exp=0", relock_count); end
  endtask

  task automatic test_lock_loss();
    do_reset();
    for (int i = 0; i <= 75; i++) begin
      if (i > 0) step();
      if (cyc == 42) begin
        checks++; if ({ready, domain_rst} !== 4'b1000) begin errors++; $display("FAIL loss_before got=%b exp=1000", {ready, domain_rst}); end
      end
      if (cyc == 43) begin
        checks++; if ({ready, domain_rst} !== 4'b0111) begin errors++; $display("FAIL loss_after got=%b exp=0111", {ready, domain_rst}); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (relock_count !== 8'd1) begin errors++; $display("FAIL loss_relock got=%0d exp=1", relock_count); end
      end
      if (cyc == 46) begin
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL loss_pulse_end got=%b exp=1", pll_rst); end
      end
      if (cyc == 47) begin
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL loss_pulse_off got=%b exp=0", pll_rst); end
      end
      if (cyc == 60) begin
        checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL loss_rel_early got=%b exp=111", domain_rst); end
      end
      if (cyc == 61) begin
        checks++; if (domain_rst !== 3'b110) begin errors++; $display("FAIL loss_rel0 got=%b exp=110", domain_rst); end
      end
      if (cyc == 71) begin
        checks++; if ({ready, domain_rst} !== 4'b0000) begin errors++; $display("FAIL loss_rel2 got=%b exp=0000", {ready, domain_rst}); end
      end
      if (cyc == 72) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_run got=%b exp=1", ready); end
        checks++; if (relock_count !== 8'd1) begin errors++; $display("FAIL loss_relock_hold got=%0d exp=1", relock_count); end
      end
      if (cyc == 10) pll_locked = 1'b1;
      if (cyc == 40) pll_locked = 1'b0;
      if (cyc == 50) pll_locked = 1'b1;
    end
  endtask

  task automatic test_force_release();
    do_reset();
    for (int i = 0; i <= 55; i++) begin
      if (i > 0) step();
      if (cyc == 23) begin
        checks++; if (domain_rst !== 3'b110) begin errors++; $display("FAIL frc_pre got=%b exp=110", domain_rst); end
      end
      if (cyc == 24) begin
        checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL frc_domain got=%b exp=111", domain_rst); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL frc_pll_rst got=%b exp=1", pll_rst); end
        checks++; if (relock_count !== 8'd1) begin errors++; $display("FAIL frc_relock got=%0d exp=1", relock_count); end
      end
      if (cyc == 36) begin
        checks++; if (domain_rst !== 3'b111) begin errors++; $display("FAIL frc_rel_early got=%b exp=111", domain_rst); end
      end
      if (cyc == 37) begin
        checks++; if (domain_rst !== 3'b110) begin errors++; $display("FAIL frc_rel0 got=%b exp=110", domain_rst); end
      end
      if (cyc == 48) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL frc_run got=%b exp=1", ready); end
      end
      if (cyc == 52) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL both_pre got=%b exp=1", ready); end
      end
      if (cyc == 53) begin
        checks++; if ({ready, domain_rst} !== 4'b0111) begin errors++; $display("FAIL both_domain got=%b exp=0111", {ready, domain_rst}); end
      end
      if (cyc == 55) begin
        checks++; if (relock_count !== 8'd2) begin errors++; $display("FAIL both_relock got=%0d exp=2", relock_count); end
      end
      force_relock = (cyc == 23) || (cyc == 52);
      if (cyc == 10) pll_locked = 1'b1;
      if (cyc == 50) pll_locked = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL frc_async_relock got=%0d exp=0", relock_count); end
  endtask

  task automatic test_force_wait();
    do_reset();
    for (int i = 0; i <= 79; i++) begin
      if (i > 0) step();
      if (cyc == 3 || cyc == 11 || cyc == 14) begin
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL fw_pll_rst_hi c=%0d got=%b exp=1", cyc, pll_rst); end
      end
      if (cyc == 4 || cyc == 15 || cyc == 78) begin
        checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL fw_pll_rst_lo c=%0d got=%b exp=0", cyc, pll_rst); end
      end
      if (cyc == 78) begin
        checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL fw_timeout_pre got=%0d exp=0", timeout_count); end
      end
      if (cyc == 79) begin
        checks++; if (timeout_count !== 8'd1) begin errors++; $display("FAIL fw_timeout got=%0d exp=1", timeout_count); end
        checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL fw_repulse got=%b exp=1", pll_rst); end
        checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL fw_relock got=%0d exp=0", relock_count); end
      end
      force_relock = (cyc == 1) || (cyc == 10);
    end
  endtask

  task automatic test_no_lock();
    int k;
    int ph;
    int exp_to;
    do_reset();
    for (int i = 0; i <= 258 * 68 + 4; i++) begin
      if (i > 0) step();
      k = cyc / 68;
      ph = cyc % 68;
      exp_to = (k > 255) ? 255 : k;
      if (ph == 0 || ph == 3 || ph == 4 || ph == 67) begin
        checks++; if (pll_rst !== (ph <= 3)) begin errors++; $display("FAIL nolock_pll_rst c=%0d got=%b exp=%b", cyc, pll_rst, (ph <= 3)); end
        checks++; if (timeout_count !== 8'(exp_to)) begin errors++; $display("FAIL nolock_timeout c=%0d got=%0d exp=%0d", cyc, timeout_count, exp_to); end
      end
    end
    checks++; if ({ready, domain_rst} !== 4'b0111) begin errors++; $display("FAIL nolock_domain got=%b exp=0111", {ready, domain_rst}); end
    checks++; if (relock_count !== 8'd0) begin errors++; $display("FAIL nolock_relock got=%0d exp=0", relock_count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL nolock_async_timeout got=%0d exp=0", timeout_count); end
  endtask

`ifdef PLL_PHASE_STEP_EN
  task automatic test_phase_step();
    do_reset();
    for (int i = 0; i <= 97; i++) begin
      if (i > 0) step();
      if (cyc == 34) begin
        checks++; if ({pll_phasesel, pll_phasestep} !== 3'b000) begin errors++; $display("FAIL ph_idle got=%b exp=000", {pll_phasesel, pll_phasestep}); end
      end
      if (cyc == 35) begin
        checks++; if ({pll_phasesel, pll_phasedir, pll_phasestep} !== 4'b1010) begin errors++; $display("FAIL ph_setup got=%b exp=1010", {pll_phasesel, pll_phasedir, pll_phasestep}); end
      end
      if (cyc == 38 || cyc == 43 || cyc == 56) begin
        checks++; if (pll_phasestep !== 1'b0) begin errors++; $display("FAIL ph_step_lo c=%0d got=%b exp=0", cyc, pll_phasestep); end
      end
      if (cyc == 39 || cyc == 42 || cyc == 55) begin
        checks++; if (pll_phasestep !== 1'b1) begin errors++; $display("FAIL ph_step_hi c=%0d got=%b exp=1", cyc, pll_phasestep); end
      end
      if (cyc == 46 || (cyc >= 56 && cyc <= 94)) begin
        checks++; if (phase_ack !== 1'b0) begin errors++; $display("FAIL ph_noack c=%0d got=%b exp=0", cyc, phase_ack); end
      end
      if (cyc == 47 || cyc == 95) begin
        checks++; if (phase_ack !== 1'b1) begin errors++; $display("FAIL ph_ack c=%0d got=%b exp=1", cyc, phase_ack); end
        phase_req = 1'b0;
      end
      if (cyc == 56) begin
        checks++; if ({ready, relock_count} !== 9'd1) begin errors++; $display("FAIL ph_abort got=%b exp=000000001", {ready, relock_count}); end
      end
      if (cyc == 83) begin
        checks++; if (pll_phasesel !== 2'd2) begin errors++; $display("FAIL ph_replay got=%0d exp=2", pll_phasesel); end
      end
      checks++; if (pll_phaseloadreg !== 1'b0) begin errors++; $display("FAIL ph_loadreg c=%0d got=%b exp=0", cyc, pll_phaseloadreg); end
      if (cyc == 10 || cyc == 60) pll_locked = 1'b1;
      if (cyc == 53) pll_locked = 1'b0;
      if (cyc == 34 || cyc == 50) begin
        phase_req = 1'b1;
        phase_sel = 2'd2;
        phase_dir = 1'b1;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_lock_loss();
    test_force_release();
    test_force_wait();
    test_no_lock();
`ifdef PLL_PHASE_STEP_EN
    test_phase_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
